alu_cond_logic: RTL
===================

Name: alu_cond_logic

Overview:
Consumer side of the ALU_ARM flag outputs. Latches the NZCV flags produced by the ALU into an architectural flag register, evaluates the 4-bit ARM condition field of each issued instruction against the stored flags, and gates the instruction's write strobes (PC, register file, memory).
Sits between the decoder/ALU and the register file, memory and PC logic. Outputs are registered with one-cycle latency and a valid qualifier.

Parameters:
FLAGS_RESET, 4'b0000, reset value of the stored {N,Z,C,V}
UNDEF_EXEC, 0, when 1, Cond=4'b1111 executes like AL; when 0, it is suppressed and flagged

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
valid_in  in  1  instruction presented this cycle
Cond  in  4  ARM condition field, instr[31:28]
ALUFlags  in  4  {Negative,Zero,Carry,Overflow} from ALU_ARM for this instruction
FlagW  in  2  [1]=update N,Z; [0]=update C,V
PCS  in  1  instruction writes PC
RegW  in  1  instruction writes register file
MemW  in  1  instruction writes memory
NoWrite  in  1  compare-type op; suppresses RegW
valid_out  out  1  registered outputs below are valid
CondEx  out  1  condition passed for the registered instruction
PCSrc  out  1  PCS & CondEx
RegWrite  out  1  RegW & ~NoWrite & CondEx
MemWrite  out  1  MemW & CondEx
Undef  out  1  Cond==4'b1111 seen (registered)
Flags  out  4  current architectural {N,Z,C,V}

Behaviour:
- Reset (async, high): Flags=FLAGS_RESET. valid_out, CondEx, PCSrc, RegWrite, MemWrite and Undef are all 0. Deassertion takes effect at the next clk edge; an instruction in flight at reset is discarded.
- Condition evaluation is combinational on the stored Flags, i.e. the value before this instruction's update:
  - EQ 0000: Z; NE 0001: ~Z; CS 0010: C; CC 0011: ~C
  - MI 0100: N; PL 0101: ~N; VS 0110: V; VC 0111: ~V
  - HI 1000: C&~Z; LS 1001: ~C|Z; GE 1010: N==V; LT 1011: N!=V
  - GT 1100: ~Z&(N==V); LE 1101: Z|(N!=V); AL 1110: 1
  - 1111: result is UNDEF_EXEC; Undef=1 regardless of the parameter.
- Flag update at the clk edge, only when valid_in & condpass:
  - FlagW[1]=1: N,Z <= ALUFlags[3:2]
  - FlagW[0]=1: C,V <= ALUFlags[1:0]
  - Bits whose FlagW bit is 0 are held. A failed condition never updates flags.
- Output stage: at each edge valid_out<=valid_in. When valid_in=1, the strobes are registered from the evaluated values. When valid_in=0, all strobes <=0. Latency is one cycle.
- Back-to-back: an instruction at cycle t+1 sees flags written by the instruction at t. There is no bypass from ALUFlags into its own condition.
- FlagW with valid_in=0 is ignored.
- Flags output always reflects the register, not the pending update.

Decomposition:
- Package alu_cond_pkg holds:
  - condition-code constants COND_EQ..COND_AL, COND_UNDEF
  - flag bit indices FLAG_N=3, FLAG_Z=2, FLAG_C=1, FLAG_V=0
  - a pure function cond_check(cond, flags) for reuse in the bench model.
- One sub-module, alu_cond_check: the combinational condition evaluator. The top level holds the flag register and the output stage.

Test Plan:
- Reset with FLAGS_RESET=0, then present Cond=AL, FlagW=2'b11, ALUFlags=4'b0010 (ALU_ARM SUB, A=7, B=4, Result=3) -> next cycle valid_out=1, CondEx=1, Flags=4'b0010.
- With Flags=0010, issue Cond=CS, RegW=1 -> RegWrite=1. Then issue Cond=EQ, RegW=1 -> CondEx=0, RegWrite=0, Flags unchanged.
- Issue Cond=AL, FlagW=2'b10, ALUFlags=4'b0100 (SUB A=4, B=4) from Flags=0010 -> Flags=0110 (C,V preserved). Next cycle Cond=LS -> CondEx=1.
- Issue Cond=NE, FlagW=2'b11, ALUFlags=4'b1001 with Z=1 stored -> CondEx=0 and Flags unchanged. Then NoWrite=1, RegW=1, Cond=AL -> RegWrite=0.
- Issue Cond=4'b1111 with UNDEF_EXEC=0, MemW=1 -> Undef=1, MemWrite=0. Assert reset mid-stream -> all outputs 0 and Flags=FLAGS_RESET immediately, without waiting for a clk edge.
- Hold valid_in low for 3 cycles while toggling FlagW and ALUFlags -> Flags stable and valid_out=0. Then run an exhaustive sweep of all 16 Cond values × 16 flag patterns against cond_check.

Source files
------------

// File: rtl/alu_cond_pkg.sv
// Shared definitions for the ARM condition-code stage: condition encodings,
// NZCV bit positions and the pure condition evaluator.
package alu_cond_pkg;

    localparam logic [3:0] COND_EQ    = 4'b0000;
    localparam logic [3:0] COND_NE    = 4'b0001;
    localparam logic [3:0] COND_CS    = 4'b0010;
    localparam logic [3:0] COND_CC    = 4'b0011;
    localparam logic [3:0] COND_MI    = 4'b0100;
    localparam logic [3:0] COND_PL    = 4'b0101;
    localparam logic [3:0] COND_VS    = 4'b0110;
    localparam logic [3:0] COND_VC    = 4'b0111;
    localparam logic [3:0] COND_HI    = 4'b1000;
    localparam logic [3:0] COND_LS    = 4'b1001;
    localparam logic [3:0] COND_GE    = 4'b1010;
    localparam logic [3:0] COND_LT    = 4'b1011;
    localparam logic [3:0] COND_GT    = 4'b1100;
    localparam logic [3:0] COND_LE    = 4'b1101;
    localparam logic [3:0] COND_AL    = 4'b1110;
    localparam logic [3:0] COND_UNDEF = 4'b1111;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    // Evaluates a condition against {N,Z,C,V}. COND_UNDEF returns 0 here;
    // whether it executes is a per-instance choice made by the caller.
    function automatic logic cond_check(input logic [3:0] cond, input logic [3:0] flags);
        logic n, z, c, v;
        n = flags[FLAG_N];
        z = flags[FLAG_Z];
        c = flags[FLAG_C];
        v = flags[FLAG_V];
        case (cond)
            COND_EQ: cond_check = z;
            COND_NE: cond_check = ~z;
            COND_CS: cond_check = c;
            COND_CC: cond_check = ~c;
            COND_MI: cond_check = n;
            COND_PL: cond_check = ~n;
            COND_VS: cond_check = v;
            COND_VC: cond_check = ~v;
            COND_HI: cond_check = c & ~z;
            COND_LS: cond_check = ~c | z;
            COND_GE: cond_check = (n == v);
            COND_LT: cond_check = (n != v);
            COND_GT: cond_check = ~z & (n == v);
            COND_LE: cond_check = z | (n != v);
            COND_AL: cond_check = 1'b1;
            default: cond_check = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/alu_cond_check.sv
// Combinational condition evaluator: decides whether the issued instruction
// passes its condition field given the currently stored flags.
module alu_cond_check
    import alu_cond_pkg::*;
#(
    parameter bit UNDEF_EXEC = 1'b0
) (
    input  logic [3:0] cond,
    input  logic [3:0] flags,
    output logic       cond_ex,
    output logic       undef
);

    // Pass/fail decision; the reserved 1111 encoding is always reported.
    always_comb begin
        undef   = (cond == COND_UNDEF);
        cond_ex = undef ? UNDEF_EXEC : cond_check(cond, flags);
    end

endmodule

// File: rtl/alu_cond_logic.sv
// Architectural NZCV register plus registered, condition-gated write strobes
// for PC, register file and memory. One cycle of latency, qualified by valid_out.
module alu_cond_logic
    import alu_cond_pkg::*;
#(
    parameter logic [3:0] FLAGS_RESET = 4'b0000,
    parameter bit         UNDEF_EXEC  = 1'b0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       valid_in,
    input  logic [3:0] Cond,
    input  logic [3:0] ALUFlags,
    input  logic [1:0] FlagW,
    input  logic       PCS,
    input  logic       RegW,
    input  logic       MemW,
    input  logic       NoWrite,
    output logic       valid_out,
    output logic       CondEx,
    output logic       PCSrc,
    output logic       RegWrite,
    output logic       MemWrite,
    output logic       Undef,
    output logic [3:0] Flags
);

    logic [3:0] flags_q;
    logic       cond_ex;
    logic       undef;
    logic       fire;

    // Evaluation uses the stored flags only: no bypass from this
    // instruction's own ALUFlags.
    alu_cond_check #(
        .UNDEF_EXEC (UNDEF_EXEC)
    ) u_check (
        .cond    (Cond),
        .flags   (flags_q),
        .cond_ex (cond_ex),
        .undef   (undef)
    );

    assign fire  = valid_in & cond_ex;
    assign Flags = flags_q;

    // Flag register: N,Z and C,V groups update independently, only for a
    // valid instruction whose condition passed.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            flags_q <= FLAGS_RESET;
        end else if (fire) begin
            if (FlagW[1]) begin
                flags_q[FLAG_N] <= ALUFlags[FLAG_N];
                flags_q[FLAG_Z] <= ALUFlags[FLAG_Z];
            end
            if (FlagW[0]) begin
                flags_q[FLAG_C] <= ALUFlags[FLAG_C];
                flags_q[FLAG_V] <= ALUFlags[FLAG_V];
            end
        end
    end

    // Output stage: strobes are forced low whenever no instruction is issued.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_out <= 1'b0;
            CondEx    <= 1'b0;
            PCSrc     <= 1'b0;
            RegWrite  <= 1'b0;
            MemWrite  <= 1'b0;
            Undef     <= 1'b0;
        end else begin
            valid_out <= valid_in;
            CondEx    <= fire;
            PCSrc     <= fire & PCS;
            RegWrite  <= fire & RegW & ~NoWrite;
            MemWrite  <= fire & MemW;
            Undef     <= valid_in & undef;
        end
    end

endmodule
